// File: rtl/ula_arbitro.sv
// Round-robin arbiter sharing one combinational ULA between two requesters.
// It registers the granted operands, captures the ULA result one cycle later and answers with a pronto pulse.
module ula_arbitro #(
    parameter int bits_palavra = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [bits_palavra-1:0] opA0,
    input  logic [bits_palavra-1:0] opB0,
    input  logic [bits_palavra-1:0] opA1,
    input  logic [bits_palavra-1:0] opB1,
    input  logic [4:0]              ctrl0,
    input  logic [4:0]              ctrl1,
    output logic                    gnt0,
    output logic                    gnt1,
    output logic                    pronto0,
    output logic                    pronto1,
    output logic                    erro,
    output logic [bits_palavra-1:0] resultado,
    output logic [3:0]              flags,
    output logic [bits_palavra-1:0] ula_operandoA,
    output logic [bits_palavra-1:0] ula_operandoB,
    output logic [4:0]              ula_controle,
    input  logic [bits_palavra-1:0] ula_resultado,
    input  logic                    ula_Z,
    input  logic                    ula_C,
    input  logic                    ula_S,
    input  logic                    ula_O
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        EXECUTA  = 2'd1,
        RESPONDE = 2'd2
    } estado_t;

    estado_t                 state_reg, state_next;
    logic                    ultimo_reg;
    logic                    invalido_reg;
    logic [bits_palavra-1:0] opa_reg, opb_reg, resultado_reg;
    logic [4:0]              ctrl_reg;
    logic [3:0]              flags_reg;

    logic                    algum_req;
    logic                    sel;
    logic [bits_palavra-1:0] opa_sel, opb_sel;
    logic [4:0]              ctrl_sel;
    logic [1:0]              gnt_vec, pronto_vec;
    logic                    erro_next;

    function automatic logic codigo_valido(input logic [4:0] c);
        case (c)
            5'b00000, 5'b00001, 5'b00011,
            5'b00100, 5'b00101, 5'b00110: codigo_valido = 1'b1;
            default:                      codigo_valido = 1'b0;
        endcase
    endfunction

    // On a conflict the requester that was not served last wins.
    always_comb begin
        algum_req = req0 | req1;
        sel       = (req0 && req1) ? ~ultimo_reg : req1;
        opa_sel   = sel ? opA1  : opA0;
        opb_sel   = sel ? opB1  : opB0;
        ctrl_sel  = sel ? ctrl1 : ctrl0;
    end

    always_comb begin
        state_next = state_reg;
        gnt_vec    = 2'b00;
        pronto_vec = 2'b00;
        erro_next  = 1'b0;
        case (state_reg)
            OCIOSO: begin
                if (algum_req) begin
                    gnt_vec[sel] = 1'b1;
                    state_next   = EXECUTA;
                end
            end
            EXECUTA: begin
                state_next = RESPONDE;
            end
            RESPONDE: begin
                // ultimo still names the owner of the in-flight transaction.
                pronto_vec[ultimo_reg] = 1'b1;
                erro_next              = invalido_reg;
                state_next             = OCIOSO;
            end
            default: begin
                state_next = OCIOSO;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= OCIOSO;
            ultimo_reg    <= 1'b1;
            invalido_reg  <= 1'b0;
            opa_reg       <= '0;
            opb_reg       <= '0;
            ctrl_reg      <= '0;
            resultado_reg <= '0;
            flags_reg     <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == OCIOSO && algum_req) begin
                opa_reg      <= opa_sel;
                opb_reg      <= opb_sel;
                ctrl_reg     <= ctrl_sel;
                ultimo_reg   <= sel;
                invalido_reg <= ~codigo_valido(ctrl_sel);
            end
            // The ULA result is captured straight into the output registers so it is visible with pronto.
            if (state_reg == EXECUTA) begin
                if (invalido_reg) begin
                    resultado_reg <= '0;
                end else begin
                    resultado_reg <= ula_resultado;
                    flags_reg     <= {ula_Z, ula_C, ula_S, ula_O};
                end
            end
        end
    end

    assign gnt0          = gnt_vec[0];
    assign gnt1          = gnt_vec[1];
    assign pronto0       = pronto_vec[0];
    assign pronto1       = pronto_vec[1];
    assign erro          = erro_next;
    assign resultado     = resultado_reg;
    assign flags         = flags_reg;
    assign ula_operandoA = opa_reg;
    assign ula_operandoB = opb_reg;
    assign ula_controle  = ctrl_reg;

endmodule

// File: tb/tb_ula_arbitro.sv
// Directed bench for ula_arbitro with an 8-bit word and a small add/subtract ULA attached.
module tb_ula_arbitro;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0, req1;
    logic [W-1:0] opA0, opB0, opA1, opB1;
    logic [4:0]   ctrl0, ctrl1;
    logic         gnt0, gnt1, pronto0, pronto1, erro;
    logic [W-1:0] resultado;
    logic [3:0]   flags;
    logic [W-1:0] ula_operandoA, ula_operandoB;
    logic [4:0]   ula_controle;
    logic [W-1:0] ula_resultado;
    logic         ula_Z, ula_C, ula_S, ula_O;

    int nvec = 0;
    int nerr = 0;

    ula_arbitro #(.bits_palavra(W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .opA0(opA0), .opB0(opB0), .opA1(opA1), .opB1(opB1),
        .ctrl0(ctrl0), .ctrl1(ctrl1),
        .gnt0(gnt0), .gnt1(gnt1), .pronto0(pronto0), .pronto1(pronto1),
        .erro(erro), .resultado(resultado), .flags(flags),
        .ula_operandoA(ula_operandoA), .ula_operandoB(ula_operandoB),
        .ula_controle(ula_controle), .ula_resultado(ula_resultado),
        .ula_Z(ula_Z), .ula_C(ula_C), .ula_S(ula_S), .ula_O(ula_O)
    );

    always #5 clk = ~clk;

    // Attached ULA: add, subtract (C = borrow), anything else ANDs.
    logic [W-1:0] m_r;
    logic         m_c, m_o;
    always_comb begin
        m_r = '0;
        m_c = 1'b0;
        m_o = 1'b0;
        case (ula_controle)
            5'b00000: begin
                {m_c, m_r} = {1'b0, ula_operandoA} + {1'b0, ula_operandoB};
                m_o = (ula_operandoA[W-1] == ula_operandoB[W-1]) && (m_r[W-1] != ula_operandoA[W-1]);
            end
            5'b00001: begin
                m_r = ula_operandoA - ula_operandoB;
                m_c = ula_operandoA < ula_operandoB;
                m_o = (ula_operandoA[W-1] != ula_operandoB[W-1]) && (m_r[W-1] != ula_operandoA[W-1]);
            end
            default: m_r = ula_operandoA & ula_operandoB;
        endcase
    end
    assign ula_resultado = m_r;
    assign ula_Z = (m_r == '0);
    assign ula_S = m_r[W-1];
    assign ula_C = m_c;
    assign ula_O = m_o;

    task automatic verifica(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic ciclo;
        @(posedge clk);
        #1;
    endtask

    task automatic amostra;
        @(negedge clk);
    endtask

    task automatic txn(input string tag, input int k);
        $display("txn %s req%0d erro=%b resultado=%0h flags=%b", tag, k, erro, resultado, flags);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0;
        opA0 = 0; opB0 = 0; opA1 = 0; opB1 = 0;
        ctrl0 = 0; ctrl1 = 0;
        amostra;
        verifica("rst_gnt", {gnt1, gnt0}, 2'b00);
        verifica("rst_pronto", {pronto1, pronto0}, 2'b00);
        verifica("rst_erro", erro, 1'b0);
        verifica("rst_resultado", resultado, 8'h00);
        verifica("rst_flags", flags, 4'b0000);
        verifica("rst_ulaA", ula_operandoA, 8'h00);
        verifica("rst_ulactl", ula_controle, 5'b00000);
        ciclo; rst = 1'b0;
        amostra;

        // 100 + 50 on requester 0
        ciclo; req0 = 1; opA0 = 8'd100; opB0 = 8'd50; ctrl0 = 5'b00000;
        amostra;
        verifica("s1_gnt", {gnt1, gnt0}, 2'b01);
        ciclo; req0 = 0;
        amostra;
        verifica("s1_ulaA", ula_operandoA, 8'd100);
        verifica("s1_ulaB", ula_operandoB, 8'd50);
        verifica("s1_n1_pronto", {pronto1, pronto0}, 2'b00);
        verifica("s1_n1_gnt", {gnt1, gnt0}, 2'b00);
        ciclo;
        amostra;
        txn("soma", 0);
        verifica("s1_pronto", {pronto1, pronto0}, 2'b01);
        verifica("s1_resultado", resultado, 8'h96);
        verifica("s1_flags", flags, 4'b0011);
        verifica("s1_erro", erro, 1'b0);

        // invalid code from requester 1
        ciclo; req1 = 1; opA1 = 8'h3C; opB1 = 8'h0F; ctrl1 = 5'b01111;
        amostra;
        verifica("inv_gnt", {gnt1, gnt0}, 2'b10);
        ciclo; req1 = 0;
        amostra;
        verifica("inv_ulactl", ula_controle, 5'b01111);
        ciclo;
        amostra;
        txn("invalido", 1);
        verifica("inv_pronto", {pronto1, pronto0}, 2'b10);
        verifica("inv_erro", erro, 1'b1);
        verifica("inv_resultado", resultado, 8'h00);
        verifica("inv_flags", flags, 4'b0011);
        ciclo;
        amostra;
        verifica("inv_erro_pulse", erro, 1'b0);

        // both requesting for 12 cycles: grants 0,1,0,1
        opA0 = 8'd20; opB0 = 8'd3; ctrl0 = 5'b00001;
        opA1 = 8'd3;  opB1 = 8'd20; ctrl1 = 5'b00001;
        for (int c = 0; c < 12; c++) begin
            ciclo;
            if (c == 0) begin
                req0 = 1; req1 = 1;
            end
            amostra;
            begin
                logic [1:0] eg, ep;
                int         dono;
                dono = (c / 3) % 2;
                eg = 2'b00;
                ep = 2'b00;
                if (c % 3 == 0) eg = (dono == 0) ? 2'b01 : 2'b10;
                if (c % 3 == 2) ep = (dono == 0) ? 2'b01 : 2'b10;
                verifica($sformatf("rr_gnt_c%0d", c), {gnt1, gnt0}, eg);
                verifica($sformatf("rr_pronto_c%0d", c), {pronto1, pronto0}, ep);
                if (c % 3 == 2) begin
                    txn("rr", dono);
                    verifica($sformatf("rr_res_c%0d", c), resultado, (dono == 0) ? 8'h11 : 8'hEF);
                end
            end
        end
        ciclo; req0 = 0; req1 = 0;
        amostra;
        verifica("rr_end_gnt", {gnt1, gnt0}, 2'b00);
        verifica("rr_flags", flags, 4'b0110);

        // 5 - 5 on requester 0
        ciclo; req0 = 1; opA0 = 8'd5; opB0 = 8'd5; ctrl0 = 5'b00001;
        amostra;
        verifica("z_gnt", {gnt1, gnt0}, 2'b01);
        ciclo; req0 = 0;
        ciclo;
        amostra;
        txn("sub_zero", 0);
        verifica("z_pronto", {pronto1, pronto0}, 2'b01);
        verifica("z_resultado", resultado, 8'h00);
        verifica("z_flags", flags, 4'b1000);

        // req0 drops in gnt+1 and rises again in RESPONDE: one transaction only
        ciclo; req0 = 1; opA0 = 8'd9; opB0 = 8'd4; ctrl0 = 5'b00000;
        amostra;
        verifica("tg_gnt", {gnt1, gnt0}, 2'b01);
        ciclo; req0 = 0;
        amostra;
        verifica("tg_n1_gnt", {gnt1, gnt0}, 2'b00);
        ciclo; req0 = 1;
        amostra;
        txn("toggle", 0);
        verifica("tg_n2_gnt", {gnt1, gnt0}, 2'b00);
        verifica("tg_pronto", {pronto1, pronto0}, 2'b01);
        verifica("tg_resultado", resultado, 8'h0D);
        ciclo; req0 = 0;
        amostra;
        verifica("tg_n3_gnt", {gnt1, gnt0}, 2'b00);
        verifica("tg_n3_pronto", {pronto1, pronto0}, 2'b00);

        // asynchronous reset during EXECUTA
        ciclo; req0 = 1; opA0 = 8'd1; opB0 = 8'd2; ctrl0 = 5'b00000;
        amostra;
        verifica("ar_gnt", {gnt1, gnt0}, 2'b01);
        ciclo; req0 = 0;
        #2 rst = 1'b1;
        #1;
        verifica("ar_resultado", resultado, 8'h00);
        verifica("ar_flags", flags, 4'b0000);
        verifica("ar_ulaA", ula_operandoA, 8'h00);
        verifica("ar_pronto", {pronto1, pronto0}, 2'b00);
        amostra;
        rst = 1'b0;
        ciclo;
        amostra;
        verifica("ar_no_pronto", {pronto1, pronto0}, 2'b00);
        // both request right after reset: requester 0 must win
        ciclo; req0 = 1; req1 = 1; opA1 = 8'd7; opB1 = 8'd7;
        amostra;
        verifica("ar_regnt", {gnt1, gnt0}, 2'b01);
        ciclo; req0 = 0; req1 = 0;
        amostra;
        verifica("ar_ulaA2", ula_operandoA, 8'd1);
        ciclo;
        amostra;
        txn("pos_reset", 0);
        verifica("ar_pronto2", {pronto1, pronto0}, 2'b01);
        verifica("ar_resultado2", resultado, 8'h03);
        verifica("ar_flags2", flags, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ula_arbitro.md
Name: ula_arbitro

Overview:
- Shares one combinational ULA instance between two requesters, 0 and 1, using round-robin arbitration.
- Registers the operands and control code for the granted requester and drives them into the ULA.
- Samples the result and the Z/C/S/O flags one cycle later and returns them to that requester with a one-cycle pronto pulse.
- Keeps an architectural flag register holding the last valid operation's flags; it sits between the instruction-issue logic and the ULA.

Parameters:
- bits_palavra, 32, data word width of operands and result (same meaning as in the ULA).

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0, req1  in  1  operation request from requester k (level).
- opA0, opB0, opA1, opB1  in  bits_palavra  signed operands from requester k.
- ctrl0, ctrl1  in  5  ULA control code from requester k.
- gnt0, gnt1  out  1  one-cycle pulse: request k accepted and operands latched this cycle.
- pronto0, pronto1  out  1  one-cycle pulse: result for requester k is valid this cycle.
- erro  out  1  accompanies pronto when the control code was invalid.
- resultado  out  bits_palavra  result of the last completed operation.
- flags  out  4  {Z,C,S,O} of the last valid completed operation.
- ula_operandoA, ula_operandoB  out  bits_palavra  registered drive to the ULA.
- ula_controle  out  5  registered drive to the ULA.
- ula_resultado  in  bits_palavra  ULA result.
- ula_Z, ula_C, ula_S, ula_O  in  1  ULA flags.

Behaviour:
- Reset values (asynchronous):
  - State is OCIOSO; all ula_* outputs, resultado and flags are 0.
  - gnt*, pronto* and erro are 0.
  - The round-robin pointer ultimo is 1, so requester 0 wins the first conflict.
- Valid control codes: 00000 soma, 00001 subtração, 00011, 00100, 00101, 00110. All other codes are invalid.
- FSM states: OCIOSO, EXECUTA, RESPONDE.
- OCIOSO:
  - If exactly one req is high, that requester is selected.
  - If both are high, the requester other than ultimo is selected.
  - In the selection cycle: gnt_k pulses; opA_k, opB_k and ctrl_k are latched into the ula_* registers; ultimo is set to k; the latched code's validity is stored in invalido. Next state is EXECUTA.
  - If no req is high, stay in OCIOSO.
- EXECUTA:
  - The ULA settles on the registered inputs.
  - At the edge, ula_resultado and ula_Z/C/S/O are captured into internal result and flag registers.
  - Next state is RESPONDE.
- RESPONDE:
  - pronto_k is high for exactly one cycle and resultado is updated.
  - If invalido: erro=1, resultado=0, flags register unchanged.
  - Otherwise: erro=0, flags = captured {Z,C,S,O}.
  - Next state is OCIOSO.
- Latency: gnt is in cycle N and pronto_k in cycle N+2. Next gnt is at N+3 at the earliest; throughput is 1 operation per 3 cycles.
- Handshake:
  - Requesters must hold their inputs stable only in the gnt cycle.
  - req is sampled only in OCIOSO. A req that stays high after pronto is treated as a new request.
  - req changes in EXECUTA/RESPONDE are ignored.
- Output persistence: resultado, flags and ula_* hold their values between operations and do not return to 0.
- No simultaneous grants: at most one gnt and one pronto are asserted per cycle, always for the same k within a transaction.
- Reset mid-operation: state returns to OCIOSO immediately, with no pronto and no flags update. An in-flight transaction is lost.
- Width: no arithmetic is performed in this block; values pass through bit-exact with bits_palavra bits.

Test Plan (bits_palavra=8):
- req0=1, opA0=100, opB0=50, ctrl0=00000, req1=0 → gnt0 at N, ula_operandoA=8'd100 at N+1, pronto0 at N+2, resultado=8'h96, flags={0,0,1,1}, erro=0.
- req0 and req1 both held high for 12 cycles, ctrl=00001 → grants alternate 0,1,0,1 at N, N+3, N+6, N+9; each pronto_k follows its own gnt_k by exactly 2 cycles.
- req1=1, ctrl1=01111 → pronto1 at N+2 with erro=1, resultado=0; flags retain the previous value {0,0,1,1}.
- After the first scenario, opA0=5, opB0=5, ctrl0=00001 → resultado=0, flags={1,0,0,0} (C as defined by the ULA for no borrow).
- rst pulsed high asynchronously in the EXECUTA cycle → no pronto follows; all outputs read 0 immediately; the next req0 is granted from OCIOSO.
- req0 toggled low in the gnt+1 cycle → the transaction still completes with pronto0 at N+2 and no second gnt.
